// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: registered PS/2 scancode decoder with held direction, auto-repeat move pulses and activate pulse
module ps2_key_decoder #(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       move,
  output logic [1:0] dir,
  output logic       activate,
  output logic       key_held
);
  localparam int CW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [CW-1:0] DLY = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER = CW'(REPEAT_PERIOD - 1);
  localparam logic [1:0] IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3;
  logic [1:0] state, state_next;
  logic [CW-1:0] cnt;
  logic [8:0] held, key;
  logic space_down, code_ev, brk_ev, dir_hit, new_make, release_hit, space_ev;
  logic [1:0] dir_map;
  assign key = {state == EXT || state == EXT_BRK, received_data};
  assign brk_ev = state == BRK || state == EXT_BRK;
  always_comb begin
    state_next = !received_data_en ? state :
                 (state == IDLE && received_data == 8'hE0) ? EXT :
                 (state == IDLE && received_data == 8'hF0) ? BRK :
                 (state == EXT  && received_data == 8'hF0) ? EXT_BRK : IDLE;
    code_ev = received_data_en &&
              !(state == IDLE && (received_data == 8'hE0 || received_data == 8'hF0)) &&
              !(state == EXT && received_data == 8'hF0);
  end
  always_comb begin
    dir_hit = 1'b1;
    dir_map = 2'b00;
    case (key)
      9'h01D, 9'h175: dir_map = 2'b11;
      9'h01C, 9'h16B: dir_map = 2'b01;
      9'h01B, 9'h172: dir_map = 2'b00;
      9'h023, 9'h174: dir_map = 2'b10;
      default:        dir_hit = 1'b0;
    endcase
  end
  assign new_make    = code_ev && dir_hit && !brk_ev && (!key_held || held != key);
  assign release_hit = code_ev && dir_hit && brk_ev && key_held && held == key;
  assign space_ev    = code_ev && key == 9'h029;
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      move       <= 1'b0;
      activate   <= 1'b0;
      dir        <= 2'b00;
      key_held   <= 1'b0;
      space_down <= 1'b0;
      cnt        <= '0;
      held       <= '0;
    end else begin
      state    <= state_next;
      move     <= 1'b0;
      activate <= space_ev && !brk_ev && !space_down;
      if (space_ev) space_down <= !brk_ev;
      // a new key make overrides any simultaneous repeat expiry
      if (new_make) begin
        held     <= key;
        dir      <= dir_map;
        key_held <= 1'b1;
        move     <= 1'b1;
        cnt      <= DLY;
      end else if (release_hit) begin
        key_held <= 1'b0;
      end else if (key_held) begin
        move <= cnt == '0;
        cnt  <= cnt == '0 ? PER : cnt - 1'b1;
      end
    end
  end
endmodule
